instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Fetch stage that sits directly upstream of the instruction memory.
- Owns the program counter and drives the word address into the memory's combinational read port.
- Registers the returned 32-bit instruction into the IF/ID pipeline register for the decoder.
- Handles stalls from hazard logic, redirects from the execute stage, and a halt when the PC runs off the end of the program store.

Parameters:
- ADDR_W, 16, width of the PC and of the instruction address.
- MEM_DEPTH, 256, number of implemented instruction words; a PC at or above this value halts fetch.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  decode or hazard unit requests that PC and IF/ID hold.
- redirect_valid  in  1  execute stage resolved a control-flow change.
- redirect_target  in  ADDR_W  new PC when redirect_valid is high.
- inst_address  out  ADDR_W  word address to instruction memory; always equal to pc.
- inst_data  in  32  combinational read data from instruction memory.
- ifid_valid  out  1  IF/ID register holds a live instruction.
- ifid_inst  out  32  fetched instruction.
- ifid_pc  out  ADDR_W  address that ifid_inst was fetched from.
- ifid_pred_taken  out  1  fetch predicted this branch taken (see Optional Feature).
- halted  out  1  fetch is in HALT.
- fetch_count  out  16  count of instructions delivered to IF/ID; saturates at 0xFFFF.

Behaviour:
- Addressing: word-addressed memory. Sequential next PC is pc+1, truncated to ADDR_W.
- Reset, synchronous with priority over everything:
  - pc=RESET_PC, state=IDLE.
  - ifid_valid=0, ifid_inst=0, ifid_pc=0, ifid_pred_taken=0.
  - halted=0, fetch_count=0.
- FSM states:
  - IDLE: one bubble cycle after reset; pc is held, ifid_valid=0, and the state goes unconditionally to RUN.
  - RUN: normal fetch.
  - HALT: pc is held, ifid_valid=0, halted=1.
- Priority per edge in RUN: redirect_valid, then stall, then normal fetch.
- redirect_valid=1:
  - pc<=redirect_target and ifid_valid<=0, squashing the wrong-path instruction. This applies even if stall=1.
  - If redirect_target>=MEM_DEPTH, go to HALT.
  - fetch_count is unchanged.
- stall=1 with no redirect: pc, all ifid_* and fetch_count hold their values.
- Normal fetch:
  - ifid_inst<=inst_data, ifid_pc<=pc, ifid_valid<=1.
  - fetch_count is incremented, saturating.
  - pc<=next PC.
  - If next PC>=MEM_DEPTH (including wrap to 0 from 0xFFFF), go to HALT after this last instruction is delivered.
- HALT:
  - A redirect with target<MEM_DEPTH loads pc and returns to RUN; stall is ignored.
  - A redirect with target>=MEM_DEPTH leaves the state in HALT.
- Latency: an instruction at address A appears on ifid_* one edge after pc==A is presented, with no stall.
- Reset mid-stall or mid-redirect: reset wins, and the next state is IDLE.

Optional Feature:
- Macro: FETCH_BTFN_PREDICT_EN.
- When defined, the fetch stage implements static backward-taken/forward-not-taken prediction:
  - A fetched word is a branch when opcode inst_data[31:29] is 3'b010 (beq) or 3'b011 (blt).
  - The target is the absolute 15-bit field inst_data[14:0], zero-extended.
  - If the target is less than pc, fetch sets pc<=target and ifid_pred_taken<=1.
  - Otherwise fetch uses the sequential next PC and ifid_pred_taken<=0.
  - The execute stage is responsible for redirecting on a misprediction.
  - A redirect in the same cycle overrides the prediction.
- When not defined, ifid_pred_taken is constant 0 and the next PC is always sequential or redirect.

Decomposition:
- Shared package cpu_pkg holds:
  - Opcode localparams: LW=000, SW=001, BEQ=010, BLT=011, ADD=100, SUB=101, AND=110, OR=111.
  - Field positions: OPC_MSB=31, OPC_LSB=29, BR_TGT_W=15.
  - ADDR_W and INST_W=32.
  - FSM state encoding: IDLE, RUN, HALT.
- Sub-module branch_predecode: combinational; takes inst_data and pc; produces is_branch, target and predict_taken. It is instantiated only under FETCH_BTFN_PREDICT_EN.

Test Plan:
- Reset, then run with the memory preloaded with a 14-word program -> cycle 1 has ifid_valid=0. From cycle 2, ifid_pc=0,1,2… consecutively and ifid_inst matches memory. fetch_count=5 after 5 deliveries.
- Hold stall=1 for 3 cycles at pc=4 -> inst_address stays 4 and ifid_pc stays 3. fetch_count is frozen. Release -> ifid_pc=4 on the next edge.
- redirect_valid=1, target=13 while pc=10, with stall=1 in the same cycle -> next edge gives pc=13 and ifid_valid=0. The following edge gives ifid_pc=13.
- Program runs sequentially to pc=255 with MEM_DEPTH=256 -> word 255 is delivered with ifid_valid=1. Then halted=1 and ifid_valid=0. A redirect to 0 resumes fetch at 0. A redirect to 300 while halted leaves halted=1.
- With FETCH_BTFN_PREDICT_EN, blt at pc=12 with field 7 -> ifid_pred_taken=1 and the next inst_address is 7. beq at pc=9 with field 13 -> ifid_pred_taken=0 and the next address is 10. Without the macro, the next address is 13 after pc=12 in both cases, and ifid_pred_taken is always 0.
- Assert reset for one cycle in the middle of a stall at pc=6 -> pc=0, ifid_valid=0, fetch_count=0, and the IDLE bubble precedes the first fetch.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions, widths and the
// fetch FSM state encoding. The fetch stage's optional static branch predictor
// is enabled with the FETCH_BTFN_PREDICT_EN macro.
package cpu_pkg;

   localparam int ADDR_W   = 16;
   localparam int INST_W   = 32;

   localparam int OPC_MSB  = 31;
   localparam int OPC_LSB  = 29;
   localparam int BR_TGT_W = 15;

   localparam logic [2:0] LW  = 3'b000;
   localparam logic [2:0] SW  = 3'b001;
   localparam logic [2:0] BEQ = 3'b010;
   localparam logic [2:0] BLT = 3'b011;
   localparam logic [2:0] ADD = 3'b100;
   localparam logic [2:0] SUB = 3'b101;
   localparam logic [2:0] AND = 3'b110;
   localparam logic [2:0] OR  = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

   // True for the conditional branch opcodes the predictor recognises.
   function automatic logic is_branch_opc(input logic [2:0] opc);
      return (opc == BEQ) || (opc == BLT);
   endfunction

endpackage

// File: rtl/branch_predecode.sv
// Combinational branch predecode for the fetch stage: flags beq/blt words,
// extracts the absolute branch target and predicts backward branches taken.
// Only built when FETCH_BTFN_PREDICT_EN is defined.
`ifdef FETCH_BTFN_PREDICT_EN
module branch_predecode
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic [INST_W-1:0] inst_data,
   input  logic [ADDR_W-1:0] pc,
   output logic              is_branch,
   output logic [ADDR_W-1:0] target,
   output logic              predict_taken
);

   logic [2:0] opc_s;

   assign opc_s         = inst_data[OPC_MSB:OPC_LSB];
   assign is_branch     = is_branch_opc(opc_s);
   // The target field is absolute and zero-extended to the PC width.
   assign target        = ADDR_W'(inst_data[BR_TGT_W-1:0]);
   // Backward-taken / forward-not-taken.
   assign predict_taken = is_branch && (target < pc);

endmodule
`endif

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address
// and registers the returned word into IF/ID. Handles stall, redirect and halt
// when the PC leaves the implemented program store.
// Optional macro FETCH_BTFN_PREDICT_EN enables static BTFN branch prediction.
module instruction_fetch
   import cpu_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int MEM_DEPTH = 256,
   parameter int RESET_PC  = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
   output logic [ADDR_W-1:0] inst_address,
   input  logic [INST_W-1:0] inst_data,
   output logic              ifid_valid,
   output logic [INST_W-1:0] ifid_inst,
   output logic [ADDR_W-1:0] ifid_pc,
   output logic              ifid_pred_taken,
   output logic              halted,
   output logic [15:0]       fetch_count
);

   // One extra bit so the end-of-store test also catches wrap past all ones.
   localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W+1)'(MEM_DEPTH);
   localparam logic [ADDR_W-1:0] RESET_PC_L = ADDR_W'(RESET_PC);

   fetch_state_e      state_r, next_state_s;
   logic [ADDR_W-1:0] pc_r, pc_s;
   logic              ifid_valid_r, ifid_valid_s;
   logic [INST_W-1:0] ifid_inst_r, ifid_inst_s;
   logic [ADDR_W-1:0] ifid_pc_r, ifid_pc_s;
   logic              ifid_pred_r, ifid_pred_s;
   logic              halted_r, halted_s;
   logic [15:0]       fetch_count_r, fetch_count_s;

   logic [ADDR_W:0]   seq_pc_s;
   logic              redirect_oob_s;
   logic              seq_oob_s;
   logic [15:0]       count_inc_s;

   assign seq_pc_s       = {1'b0, pc_r} + {{ADDR_W{1'b0}}, 1'b1};
   assign redirect_oob_s = ({1'b0, redirect_target} >= DEPTH_L);
   assign seq_oob_s      = (seq_pc_s >= DEPTH_L);
   assign count_inc_s    = (fetch_count_r == 16'hFFFF) ? fetch_count_r : (fetch_count_r + 16'd1);

`ifdef FETCH_BTFN_PREDICT_EN
   logic              is_branch_s;
   logic [ADDR_W-1:0] pred_target_s;
   logic              predict_taken_s;

   branch_predecode #(
      .ADDR_W (ADDR_W)
   ) u_predecode (
      .inst_data     (inst_data),
      .pc            (pc_r),
      .is_branch     (is_branch_s),
      .target        (pred_target_s),
      .predict_taken (predict_taken_s)
   );
`endif

   // Next-state and next-register values; every target defaults to holding.
   always_comb begin
      next_state_s  = state_r;
      pc_s          = pc_r;
      ifid_valid_s  = ifid_valid_r;
      ifid_inst_s   = ifid_inst_r;
      ifid_pc_s     = ifid_pc_r;
      ifid_pred_s   = ifid_pred_r;
      halted_s      = halted_r;
      fetch_count_s = fetch_count_r;
      case (state_r)
         IDLE: begin
            ifid_valid_s = 1'b0;
            halted_s     = 1'b0;
            next_state_s = RUN;
         end
         RUN: begin
            if (redirect_valid) begin
               // Squash the wrong-path word; redirect beats stall.
               pc_s         = redirect_target;
               ifid_valid_s = 1'b0;
               ifid_pred_s  = 1'b0;
               if (redirect_oob_s) begin
                  next_state_s = HALT;
                  halted_s     = 1'b1;
               end else begin
                  next_state_s = RUN;
               end
            end else if (stall) begin
               next_state_s = RUN;
            end else begin
               ifid_inst_s   = inst_data;
               ifid_pc_s     = pc_r;
               ifid_valid_s  = 1'b1;
               fetch_count_s = count_inc_s;
`ifdef FETCH_BTFN_PREDICT_EN
               if (is_branch_s && predict_taken_s) begin
                  // A backward target is below pc, so it stays inside the store.
                  pc_s         = pred_target_s;
                  ifid_pred_s  = 1'b1;
                  next_state_s = RUN;
               end else begin
                  pc_s        = seq_pc_s[ADDR_W-1:0];
                  ifid_pred_s = 1'b0;
                  if (seq_oob_s) begin
                     next_state_s = HALT;
                     halted_s     = 1'b1;
                  end else begin
                     next_state_s = RUN;
                  end
               end
`else
               pc_s        = seq_pc_s[ADDR_W-1:0];
               ifid_pred_s = 1'b0;
               if (seq_oob_s) begin
                  next_state_s = HALT;
                  halted_s     = 1'b1;
               end else begin
                  next_state_s = RUN;
               end
`endif
            end
         end
         HALT: begin
            ifid_valid_s = 1'b0;
            if (redirect_valid && !redirect_oob_s) begin
               pc_s         = redirect_target;
               halted_s     = 1'b0;
               next_state_s = RUN;
            end else begin
               halted_s     = 1'b1;
               next_state_s = HALT;
            end
         end
         default: begin
            ifid_valid_s = 1'b0;
            halted_s     = 1'b0;
            next_state_s = IDLE;
         end
      endcase
   end

   // State and pipeline registers; synchronous reset wins over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= IDLE;
         pc_r          <= RESET_PC_L;
         ifid_valid_r  <= 1'b0;
         ifid_inst_r   <= {INST_W{1'b0}};
         ifid_pc_r     <= {ADDR_W{1'b0}};
         ifid_pred_r   <= 1'b0;
         halted_r      <= 1'b0;
         fetch_count_r <= 16'd0;
      end else begin
         state_r       <= next_state_s;
         pc_r          <= pc_s;
         ifid_valid_r  <= ifid_valid_s;
         ifid_inst_r   <= ifid_inst_s;
         ifid_pc_r     <= ifid_pc_s;
         ifid_pred_r   <= ifid_pred_s;
         halted_r      <= halted_s;
         fetch_count_r <= fetch_count_s;
      end
   end

   assign inst_address    = pc_r;
   assign ifid_valid      = ifid_valid_r;
   assign ifid_inst       = ifid_inst_r;
   assign ifid_pc         = ifid_pc_r;
   assign ifid_pred_taken = ifid_pred_r;
   assign halted          = halted_r;
   assign fetch_count     = fetch_count_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch. A small memory model
// answers the combinational read port; expected IF/ID contents are queued
// when a fetch cycle is driven and popped when the word appears.
module tb_instruction_fetch;

`ifdef FETCH_BTFN_PREDICT_EN
   localparam bit PRED_EN = 1'b1;
`else
   localparam bit PRED_EN = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [15:0] redirect_target;
   logic [15:0] inst_address;
   logic [31:0] inst_data;
   logic        ifid_valid;
   logic [31:0] ifid_inst;
   logic [15:0] ifid_pc;
   logic        ifid_pred_taken;
   logic        halted;
   logic [15:0] fetch_count;

   logic [31:0] mem [0:255];
   logic [47:0] sb_q [$];
   int          checks;
   int          errors;
   logic [15:0] exp_count;

   instruction_fetch #(
      .ADDR_W    (16),
      .MEM_DEPTH (256),
      .RESET_PC  (0)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .inst_address    (inst_address),
      .inst_data       (inst_data),
      .ifid_valid      (ifid_valid),
      .ifid_inst       (ifid_inst),
      .ifid_pc         (ifid_pc),
      .ifid_pred_taken (ifid_pred_taken),
      .halted          (halted),
      .fetch_count     (fetch_count)
   );

   assign inst_data = (inst_address < 16'd256) ? mem[inst_address[7:0]] : 32'h0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic st, input logic rv, input logic [15:0] rt);
      stall           = st;
      redirect_valid  = rv;
      redirect_target = rt;
      @(posedge clk);
      #1;
   endtask

   // Drive one plain fetch cycle at address a and check the delivered word.
   task automatic fetch_exp(input logic [15:0] a, input logic p);
      logic [47:0] e;
      chk("addr_pre", {16'd0, inst_address}, {16'd0, a});
      sb_q.push_back({a, mem[a[7:0]]});
      cyc(1'b0, 1'b0, 16'd0);
      if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
      chk("valid", {31'd0, ifid_valid}, 32'd1);
      if (ifid_valid === 1'b1 && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("ifid_pc", {16'd0, ifid_pc}, {16'd0, e[47:32]});
         chk("ifid_inst", ifid_inst, e[31:0]);
      end
      chk("pred", {31'd0, ifid_pred_taken}, {31'd0, p});
      chk("count", {16'd0, fetch_count}, {16'd0, exp_count});
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      exp_count = 16'd0;
      for (int i = 0; i < 256; i++) mem[i] = {3'b100, 13'd0, 16'(i)};
      reset           = 1'b1;
      stall           = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 16'd0;

      // Reset state
      cyc(1'b0, 1'b0, 16'd0);
      chk("rst_pc", {16'd0, inst_address}, 32'd0);
      chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
      chk("rst_inst", ifid_inst, 32'd0);
      chk("rst_ifid_pc", {16'd0, ifid_pc}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_count", {16'd0, fetch_count}, 32'd0);
      chk("rst_pred", {31'd0, ifid_pred_taken}, 32'd0);

      // IDLE bubble then sequential fetch
      reset = 1'b0;
      cyc(1'b0, 1'b0, 16'd0);
      chk("idle_valid", {31'd0, ifid_valid}, 32'd0);
      chk("idle_pc", {16'd0, inst_address}, 32'd0);
      for (int a = 0; a < 4; a++) fetch_exp(16'(a), 1'b0);

      // Stall three cycles with pc=4
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 1'b0, 16'd0);
         chk("stall_addr", {16'd0, inst_address}, 32'd4);
         chk("stall_ifid_pc", {16'd0, ifid_pc}, 32'd3);
         chk("stall_count", {16'd0, fetch_count}, 32'd4);
      end
      fetch_exp(16'd4, 1'b0);
      chk("count5", {16'd0, fetch_count}, 32'd5);

      // Redirect with simultaneous stall at pc=10
      for (int a = 5; a < 10; a++) fetch_exp(16'(a), 1'b0);
      chk("pre_redir_addr", {16'd0, inst_address}, 32'd10);
      cyc(1'b1, 1'b1, 16'd13);
      chk("redir_addr", {16'd0, inst_address}, 32'd13);
      chk("redir_valid", {31'd0, ifid_valid}, 32'd0);
      chk("redir_count", {16'd0, fetch_count}, {16'd0, exp_count});
      fetch_exp(16'd13, 1'b0);

      // Branch predecode: beq forward at 9, blt backward at 12
      mem[9]  = {3'b010, 14'd0, 15'd13};
      mem[12] = {3'b011, 14'd0, 15'd7};
      cyc(1'b0, 1'b1, 16'd9);
      chk("br_redir_valid", {31'd0, ifid_valid}, 32'd0);
      fetch_exp(16'd9, 1'b0);
      chk("beq_next", {16'd0, inst_address}, 32'd10);
      fetch_exp(16'd10, 1'b0);
      fetch_exp(16'd11, 1'b0);
      fetch_exp(16'd12, PRED_EN);
      chk("blt_next", {16'd0, inst_address}, PRED_EN ? 32'd7 : 32'd13);
      cyc(1'b0, 1'b1, 16'd14);
      mem[9]  = {3'b100, 13'd0, 16'd9};
      mem[12] = {3'b100, 13'd0, 16'd12};

      // Run off the end of the store
      for (int a = 14; a < 256; a++) fetch_exp(16'(a), 1'b0);
      cyc(1'b0, 1'b0, 16'd0);
      chk("halt_halted", {31'd0, halted}, 32'd1);
      chk("halt_valid", {31'd0, ifid_valid}, 32'd0);
      chk("halt_count", {16'd0, fetch_count}, {16'd0, exp_count});
      cyc(1'b0, 1'b1, 16'd300);
      chk("halt_oob_halted", {31'd0, halted}, 32'd1);
      chk("halt_oob_valid", {31'd0, ifid_valid}, 32'd0);
      cyc(1'b1, 1'b1, 16'd0);
      chk("resume_halted", {31'd0, halted}, 32'd0);
      chk("resume_addr", {16'd0, inst_address}, 32'd0);
      chk("resume_valid", {31'd0, ifid_valid}, 32'd0);
      for (int a = 0; a < 6; a++) fetch_exp(16'(a), 1'b0);

      // Reset in the middle of a stall at pc=6
      cyc(1'b1, 1'b0, 16'd0);
      chk("pre_rst_addr", {16'd0, inst_address}, 32'd6);
      reset = 1'b1;
      cyc(1'b1, 1'b0, 16'd0);
      reset     = 1'b0;
      exp_count = 16'd0;
      sb_q.delete();
      chk("mid_rst_pc", {16'd0, inst_address}, 32'd0);
      chk("mid_rst_valid", {31'd0, ifid_valid}, 32'd0);
      chk("mid_rst_count", {16'd0, fetch_count}, 32'd0);
      chk("mid_rst_halted", {31'd0, halted}, 32'd0);
      cyc(1'b0, 1'b0, 16'd0);
      chk("mid_rst_bubble", {31'd0, ifid_valid}, 32'd0);
      chk("mid_rst_bubble_pc", {16'd0, inst_address}, 32'd0);
      fetch_exp(16'd0, 1'b0);
      fetch_exp(16'd1, 1'b0);

      chk("sb_drain", sb_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
